// File: rtl/rounding_pkg.sv
// Shared rounding-mode encoding plus the divider FSM states, special-operand classes and
// constants used by fp_div and round_div.
package rounding_pkg;

  // Encodings 6 and 7 are unused and behave as round-to-nearest-even.
  typedef enum logic [2:0] {
    RndIeeeNear = 3'd0,
    RndIeeeZero = 3'd1,
    RndIeeePinf = 3'd2,
    RndIeeeNinf = 3'd3,
    RndNearUp   = 3'd4,
    RndAwayZero = 3'd5
  } round_mode_t;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StDiv,
    StRound,
    StDone
  } div_state_e;

  typedef enum logic [2:0] {
    SpNone,
    SpNan,
    SpInf,
    SpDivZero,
    SpZero
  } special_e;

  localparam int unsigned ITER = 25;
  localparam int unsigned BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // status = {1'b0, div_by_zero, inexact, huge, tiny, nan, inf, zero}
  localparam logic [7:0] StatusNan     = 8'h04;
  localparam logic [7:0] StatusInf     = 8'h02;
  localparam logic [7:0] StatusDivZero = 8'h42;
  localparam logic [7:0] StatusZero    = 8'h01;

endpackage

// File: rtl/round_div.sv
// Rounds the 24-bit quotient significand with guard/sticky and applies the overflow and
// underflow result selection for the active rounding mode. Purely combinational.
module round_div
  import rounding_pkg::*;
(
  input  logic              sign_i,
  input  logic signed [9:0] exp_i,
  input  logic [23:0]       mant_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  input  logic [2:0]        rnd_i,
  output logic [31:0]       z_o,
  output logic [7:0]        status_o
);

  logic              inexact;
  logic              inc;
  logic              to_inf;
  logic              to_min;
  logic [24:0]       mant_r;
  logic signed [9:0] exp_r;
  logic [22:0]       frac;

  always_comb begin
    inexact = guard_i | sticky_i;
    inc     = guard_i & (sticky_i | mant_i[0]);
    // to_inf: overflow saturates to infinity; to_min: underflow lifts to min normal
    to_inf  = 1'b1;
    to_min  = 1'b0;
    case (rnd_i)
      RndIeeeZero: begin
        inc    = 1'b0;
        to_inf = 1'b0;
      end
      RndIeeePinf: begin
        inc    = ~sign_i & inexact;
        to_inf = ~sign_i;
        to_min = ~sign_i;
      end
      RndIeeeNinf: begin
        inc    = sign_i & inexact;
        to_inf = sign_i;
        to_min = sign_i;
      end
      RndNearUp: begin
        inc = guard_i;
      end
      RndAwayZero: begin
        inc    = inexact;
        to_min = 1'b1;
      end
      default: begin
      end
    endcase

    mant_r = {1'b0, mant_i} + {24'd0, inc};
    exp_r  = mant_r[24] ? exp_i + 10'sd1 : exp_i;
    frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    z_o      = {sign_i, exp_r[7:0], frac};
    status_o = {2'b00, inexact, 5'b00000};

    if (exp_r >= 10'sd255) begin
      if (to_inf) begin
        z_o      = {sign_i, 8'hFF, 23'd0};
        status_o = 8'h32;
      end else begin
        z_o      = {sign_i, 8'hFE, 23'h7F_FFFF};
        status_o = 8'h30;
      end
    end else if (exp_r <= 10'sd0) begin
      if (to_min) begin
        z_o      = {sign_i, 8'h01, 23'd0};
        status_o = 8'h28;
      end else begin
        z_o      = {sign_i, 31'd0};
        status_o = 8'h29;
      end
    end
  end

endmodule

// File: rtl/fp_div.sv
// Iterative single-precision divider: operand capture, prep/classification, 25-cycle
// restoring division and a registered result that holds until the next completion.
module fp_div
  import rounding_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  rnd,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] z,
  output logic [7:0]  status
);

  div_state_e        state_q, state_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [2:0]        rnd_q, rnd_d;
  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;
  logic [23:0]       mb_q, mb_d;
  logic [25:0]       rem_q, rem_d;
  logic [24:0]       quo_q, quo_d;
  logic [4:0]        cnt_q, cnt_d;
  special_e          special_q, special_d;
  logic [31:0]       z_q, z_d;
  logic [7:0]        status_q, status_d;

  logic [7:0]        ea, eb;
  logic [23:0]       ma, mb;
  logic [24:0]       ma_adj;
  logic signed [9:0] exp_raw, exp_adj;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  special_e          special_c;
  logic              rem_ge;
  logic [25:0]       rem_sub;
  logic [31:0]       rnd_z;
  logic [7:0]        rnd_status;

  // Operand unpacking and classification; subnormals flush to zero here.
  always_comb begin
    ea     = a_q[30:23];
    eb     = b_q[30:23];
    ma     = (ea == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
    mb     = (eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
    a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);

    exp_raw = 10'(ea) - 10'(eb) + 10'(BIAS);
    if (ma < mb) begin
      ma_adj  = {ma, 1'b0};
      exp_adj = exp_raw - 10'sd1;
    end else begin
      ma_adj  = {1'b0, ma};
      exp_adj = exp_raw;
    end

    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_c = SpNan;
    end else if (a_inf) begin
      special_c = SpInf;
    end else if (b_zero) begin
      special_c = SpDivZero;
    end else if (a_zero || b_inf) begin
      special_c = SpZero;
    end else begin
      special_c = SpNone;
    end
  end

  assign rem_ge  = rem_q >= {2'b00, mb_q};
  assign rem_sub = rem_ge ? rem_q - {2'b00, mb_q} : rem_q;

  round_div u_round_div (
    .sign_i   (sign_q),
    .exp_i    (exp_q),
    .mant_i   (quo_q[24:1]),
    .guard_i  (quo_q[0]),
    .sticky_i (rem_q != 26'd0),
    .rnd_i    (rnd_q),
    .z_o      (rnd_z),
    .status_o (rnd_status)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    rnd_d     = rnd_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mb_d      = mb_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    special_d = special_q;
    z_d       = z_q;
    status_d  = status_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          rnd_d   = rnd;
          state_d = StPrep;
        end
      end
      StPrep: begin
        sign_d    = a_q[31] ^ b_q[31];
        exp_d     = exp_adj;
        rem_d     = {1'b0, ma_adj};
        mb_d      = mb;
        quo_d     = 25'd0;
        cnt_d     = 5'd0;
        special_d = special_c;
        state_d   = StDiv;
      end
      StDiv: begin
        quo_d = {quo_q[23:0], rem_ge};
        rem_d = {rem_sub[24:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) begin
          state_d = StRound;
        end
      end
      StRound: begin
        // Specials still pass through every state so latency never varies.
        case (special_q)
          SpNan: begin
            z_d      = QNAN;
            status_d = StatusNan;
          end
          SpInf: begin
            z_d      = {sign_q, 8'hFF, 23'd0};
            status_d = StatusInf;
          end
          SpDivZero: begin
            z_d      = {sign_q, 8'hFF, 23'd0};
            status_d = StatusDivZero;
          end
          SpZero: begin
            z_d      = {sign_q, 31'd0};
            status_d = StatusZero;
          end
          default: begin
            z_d      = rnd_z;
            status_d = rnd_status;
          end
        endcase
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rnd_q     <= 3'd0;
      sign_q    <= 1'b0;
      exp_q     <= 10'sd0;
      mb_q      <= 24'd0;
      rem_q     <= 26'd0;
      quo_q     <= 25'd0;
      cnt_q     <= 5'd0;
      special_q <= SpNone;
      z_q       <= 32'd0;
      status_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rnd_q     <= rnd_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      mb_q      <= mb_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      special_q <= special_d;
      z_q       <= z_d;
      status_q  <= status_d;
    end
  end

  assign busy   = (state_q == StPrep) || (state_q == StDiv) || (state_q == StRound);
  assign done   = (state_q == StDone);
  assign z      = z_q;
  assign status = status_q;

endmodule

// File: tb/tb_fp_div.sv
// Directed bench for fp_div: hand-computed quotients, specials, rounding modes, latency,
// start filtering, back-to-back spacing and mid-operation reset.
module tb_fp_div;
  import rounding_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  rnd;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] z;
  logic [7:0]  status;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [31:0] z;
    logic [7:0]  st;
  } vec_t;

  fp_div dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .rnd    (rnd),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .z      (z),
    .status (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Waits for idle, launches one operation, scrambles the inputs after acceptance, and
  // returns the result plus the number of edges from the accept edge to done (-1 if none).
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] rm,
                        output logic [31:0] zo, output logic [7:0] so, output int lat);
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    a     = av;
    b     = bv;
    rnd   = rm;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    rnd   = rm ^ 3'd1;
    lat   = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) lat = -1;
    zo = z;
    so = status;
  endtask

  task automatic add_vec(inout vec_t q[$], input string nm, input logic [31:0] av,
                         input logic [31:0] bv, input logic [2:0] rm, input logic [31:0] zv,
                         input logic [7:0] sv);
    vec_t v;
    v.name = nm;
    v.a    = av;
    v.b    = bv;
    v.rm   = rm;
    v.z    = zv;
    v.st   = sv;
    q.push_back(v);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    rnd   = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (z !== 32'h0 || status !== 8'h0) begin
      errors++;
      $display("FAIL reset_result: z=%h status=%h expected 00000000 00", z, status);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] zo;
    logic [7:0]  so;
    int          lat;
    run_op(32'h40C0_0000, 32'h4000_0000, RndIeeeNear, zo, so, lat);
    checks++;
    if (zo !== 32'h4040_0000 || so !== 8'h00) begin
      errors++;
      $display("FAIL six_div_two: z=%h status=%h expected 40400000 00", zo, so);
    end
    checks++;
    if (lat !== 28) begin
      errors++;
      $display("FAIL latency: done after %0d edges expected 28", lat);
    end
    // Output must hold after done drops.
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (z !== 32'h4040_0000 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold: z=%h done=%b expected 40400000 0", z, done);
    end
  endtask

  task automatic test_vectors(input string label);
    vec_t        q[$];
    logic [31:0] zo;
    logic [7:0]  so;
    int          lat;
    if (label == "rounding") begin
      add_vec(q, "third_near",    32'h3F80_0000, 32'h4040_0000, RndIeeeNear, 32'h3EAA_AAAB, 8'h20);
      add_vec(q, "third_zero",    32'h3F80_0000, 32'h4040_0000, RndIeeeZero, 32'h3EAA_AAAA, 8'h20);
      add_vec(q, "third_nearup",  32'h3F80_0000, 32'h4040_0000, RndNearUp,   32'h3EAA_AAAB, 8'h20);
      add_vec(q, "third_mode7",   32'h3F80_0000, 32'h4040_0000, 3'd7,        32'h3EAA_AAAB, 8'h20);
      add_vec(q, "negthird_pinf", 32'hBF80_0000, 32'h4040_0000, RndIeeePinf, 32'hBEAA_AAAA, 8'h20);
      add_vec(q, "negthird_ninf", 32'hBF80_0000, 32'h4040_0000, RndIeeeNinf, 32'hBEAA_AAAB, 8'h20);
      add_vec(q, "neg_six_two",   32'hC0C0_0000, 32'h4000_0000, RndAwayZero, 32'hC040_0000, 8'h00);
    end else if (label == "special") begin
      add_vec(q, "one_div_zero",  32'h3F80_0000, 32'h0000_0000, RndIeeeNear, 32'h7F80_0000, 8'h42);
      add_vec(q, "zero_div_zero", 32'h0000_0000, 32'h0000_0000, RndIeeeNear, 32'h7FC0_0000, 8'h04);
      add_vec(q, "nan_operand",   32'h7FC0_0001, 32'h3F80_0000, RndIeeeNear, 32'h7FC0_0000, 8'h04);
      add_vec(q, "inf_div_inf",   32'h7F80_0000, 32'hFF80_0000, RndIeeeZero, 32'h7FC0_0000, 8'h04);
      add_vec(q, "neginf_div_2",  32'hFF80_0000, 32'h4000_0000, RndIeeeNear, 32'hFF80_0000, 8'h02);
      add_vec(q, "negone_div_inf", 32'hBF80_0000, 32'h7F80_0000, RndIeeeNear, 32'h8000_0000, 8'h01);
      add_vec(q, "subnorm_dvd",   32'h0040_0000, 32'h3F80_0000, RndIeeeNear, 32'h0000_0000, 8'h01);
      add_vec(q, "subnorm_dvs",   32'hBF80_0000, 32'h0040_0000, RndIeeeNear, 32'hFF80_0000, 8'h42);
    end else begin
      add_vec(q, "ovf_near",      32'h7F00_0000, 32'h3E80_0000, RndIeeeNear, 32'h7F80_0000, 8'h32);
      add_vec(q, "ovf_zero",      32'h7F00_0000, 32'h3E80_0000, RndIeeeZero, 32'h7F7F_FFFF, 8'h30);
      add_vec(q, "ovf_pinf",      32'h7F00_0000, 32'h3E80_0000, RndIeeePinf, 32'h7F80_0000, 8'h32);
      add_vec(q, "ovf_ninf",      32'h7F00_0000, 32'h3E80_0000, RndIeeeNinf, 32'h7F7F_FFFF, 8'h30);
      add_vec(q, "ovf_neg_ninf",  32'hFF00_0000, 32'h3E80_0000, RndIeeeNinf, 32'hFF80_0000, 8'h32);
      add_vec(q, "unf_near",      32'h0080_0000, 32'h4000_0000, RndIeeeNear, 32'h0000_0000, 8'h29);
      add_vec(q, "unf_away",      32'h0080_0000, 32'h4000_0000, RndAwayZero, 32'h0080_0000, 8'h28);
      add_vec(q, "unf_neg_pinf",  32'h8080_0000, 32'h4000_0000, RndIeeePinf, 32'h8000_0000, 8'h29);
    end
    foreach (q[i]) begin
      run_op(q[i].a, q[i].b, q[i].rm, zo, so, lat);
      checks++;
      if (zo !== q[i].z || so !== q[i].st || lat !== 28) begin
        errors++;
        $display("FAIL %s: z=%h status=%h lat=%0d expected %h %h 28",
                 q[i].name, zo, so, lat, q[i].z, q[i].st);
      end
    end
  endtask

  task automatic test_ignore_start();
    int          dones = 0;
    int          first = 0;
    logic [31:0] zf = 32'h0;
    logic [7:0]  sf = 8'h0;
    @(negedge clk);
    while (busy || done) @(negedge clk);
    a     = 32'h40C0_0000;
    b     = 32'h4000_0000;
    rnd   = RndIeeeNear;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 2; cyc <= 70; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 4) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_mid_op: busy=%b expected 1", busy);
        end
        a     = 32'h3F80_0000;
        b     = 32'h4040_0000;
        start = 1'b1;
      end
      if (cyc == 5) start = 1'b0;
      if (done) begin
        dones++;
        if (first == 0) begin
          first = cyc;
          zf    = z;
          sf    = status;
        end
      end
    end
    checks++;
    if (dones !== 1 || first !== 28) begin
      errors++;
      $display("FAIL ignore_start: dones=%0d first=%0d expected 1 28", dones, first);
    end
    checks++;
    if (zf !== 32'h4040_0000 || sf !== 8'h00) begin
      errors++;
      $display("FAIL ignore_start_result: z=%h status=%h expected 40400000 00", zf, sf);
    end
  endtask

  task automatic test_back_to_back();
    int          d1 = 0;
    int          d2 = 0;
    logic [31:0] z1 = 32'h0;
    logic [31:0] z2 = 32'h0;
    @(negedge clk);
    while (busy || done) @(negedge clk);
    a     = 32'h40C0_0000;
    b     = 32'h4000_0000;
    rnd   = RndIeeeNear;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 32'h3F80_0000;
    b = 32'h4040_0000;
    for (int cyc = 2; cyc <= 62; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 31) start = 1'b0;
      if (done) begin
        if (d1 == 0) begin
          d1 = cyc;
          z1 = z;
        end else if (d2 == 0) begin
          d2 = cyc;
          z2 = z;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (d1 !== 28 || d2 !== 57) begin
      errors++;
      $display("FAIL back_to_back_timing: done at %0d,%0d expected 28,57", d1, d2);
    end
    checks++;
    if (z1 !== 32'h4040_0000 || z2 !== 32'h3EAA_AAAB) begin
      errors++;
      $display("FAIL back_to_back_result: z=%h,%h expected 40400000,3eaaaaab", z1, z2);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    while (busy || done) @(negedge clk);
    a     = 32'h3F80_0000;
    b     = 32'h4040_0000;
    rnd   = RndIeeeNear;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || z !== 32'h0 || status !== 8'h0) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b done=%b z=%h status=%h expected 0 0 0 0",
               busy, done, z, status);
    end
    rst   = 1'b0;
    a     = 32'h40C0_0000;
    b     = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 28 || z !== 32'h4040_0000 || status !== 8'h00) begin
      errors++;
      $display("FAIL after_reset_op: lat=%0d z=%h status=%h expected 28 40400000 00",
               lat, z, status);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors("rounding");
    test_vectors("special");
    test_vectors("range");
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
